// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared reservation-station types, constants and CDB helpers
package rs_pkg;

    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 6;
    localparam int RS_AGE_W = 4;

    localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

    typedef logic [RS_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic                busy;
        tag_t                dest_tag;
        logic [RS_XLEN-1:0]  base;
        logic                base_rdy;
        tag_t                base_tag;
        logic [RS_XLEN-1:0]  offset;
        logic [RS_AGE_W-1:0] age;
    } load_entry_t;

    // Bit position of channel ch inside a packed per-channel CDB bus of field width w.
    function automatic int cdb_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/load_rs_array_if.sv
// rtl/load_rs_array_if.sv - dispatch, CDB and issue signals of the load station
interface load_rs_array_if #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = 3
);
    logic                     disp_valid;
    logic                     disp_ready;
    logic [TAG_W-1:0]         disp_dest_tag;
    logic [XLEN-1:0]          disp_base;
    logic                     disp_base_rdy;
    logic [TAG_W-1:0]         disp_base_tag;
    logic [XLEN-1:0]          disp_offset;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [XLEN-1:0]          issue_addr;
    logic [TAG_W-1:0]         issue_tag;
    logic [CNT_W-1:0]         occupancy;

    modport master (
        output disp_valid, disp_dest_tag, disp_base, disp_base_rdy, disp_base_tag, disp_offset,
        output cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_addr, issue_tag, occupancy
    );

    modport slave (
        input  disp_valid, disp_dest_tag, disp_base, disp_base_rdy, disp_base_tag, disp_offset,
        input  cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_addr, issue_tag, occupancy
    );
endinterface

// File: rtl/oldest_ready_pick.sv
// rtl/oldest_ready_pick.sv - one-hot grant of the ready entry with the smallest age
module oldest_ready_pick #(
    parameter int DEPTH = 4,
    parameter int AGE_W = 2
) (
    input  logic [DEPTH-1:0]       cand_i,
    input  logic [DEPTH*AGE_W-1:0] age_i,
    output logic [DEPTH-1:0]       grant_o,
    output logic                   grant_valid_o
);
    logic             found;
    logic [AGE_W-1:0] best;

    // Linear scan keeping the smallest age seen; ages are unique so no tie-break is needed.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        best    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand_i[i] && (!found || age_i[i*AGE_W +: AGE_W] < best)) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                found      = 1'b1;
                best       = age_i[i*AGE_W +: AGE_W];
            end
        end
        grant_valid_o = found;
    end
endmodule

// File: rtl/load_rs_array.sv
// rtl/load_rs_array.sv - load reservation station with CDB snoop and oldest-first issue
module load_rs_array
    import rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    load_rs_array_if.slave     bus
);
    localparam int AGE_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d, rdy_q, rdy_d;
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];
    logic [TAG_W-1:0] btag_q [DEPTH];
    logic [TAG_W-1:0] btag_d [DEPTH];
    logic [XLEN-1:0]  base_q [DEPTH];
    logic [XLEN-1:0]  base_d [DEPTH];
    logic [XLEN-1:0]  off_q  [DEPTH];
    logic [XLEN-1:0]  off_d  [DEPTH];
    logic [AGE_W-1:0] age_q  [DEPTH];
    logic [AGE_W-1:0] age_d  [DEPTH];
    logic [CNT_W-1:0] occ_q, occ_d, occ_rem;

    logic             iv_q, iv_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [TAG_W-1:0] itag_q, itag_d;

    logic [DEPTH-1:0]       cand, grant;
    logic [DEPTH*AGE_W-1:0] ages_flat;
    logic                   grant_valid, issue_load, disp_fire;
    logic [AGE_W-1:0]       gage;
    logic [IDX_W-1:0]       free_idx;

    assign bus.disp_ready  = (occ_q < CNT_W'(DEPTH));
    assign bus.occupancy   = occ_q;
    assign bus.issue_valid = iv_q;
    assign bus.issue_addr  = addr_q;
    assign bus.issue_tag   = itag_q;

    // Selection only sees registered ready bits, so a same-cycle capture waits one edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i]                        = busy_q[i] && rdy_q[i];
            ages_flat[i*AGE_W +: AGE_W]    = age_q[i];
        end
    end

    oldest_ready_pick #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_pick (
        .cand_i        (cand),
        .age_i         (ages_flat),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // Next state of entries, occupancy and issue register.
    always_comb begin
        busy_d = busy_q;
        rdy_d  = rdy_q;
        dest_d = dest_q;
        btag_d = btag_q;
        base_d = base_q;
        off_d  = off_q;
        age_d  = age_q;
        iv_d   = iv_q;
        addr_d = addr_q;
        itag_d = itag_q;

        issue_load = grant_valid && (!iv_q || bus.issue_ready);
        disp_fire  = bus.disp_valid && bus.disp_ready && !flush;
        occ_rem    = occ_q - CNT_W'(issue_load);

        gage     = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (grant[i]) gage = age_q[i];
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end

        if (issue_load) begin
            iv_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[i]) begin
                    addr_d = base_q[i] + off_q[i];
                    itag_d = dest_q[i];
                end
            end
        end else if (bus.issue_ready) begin
            iv_d = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (issue_load && grant[i]) begin
                busy_d[i] = 1'b0;
            end else if (busy_q[i] && issue_load && age_q[i] > gage) begin
                age_d[i] = age_q[i] - 1'b1;
            end
            // Descending scan so the lowest matching channel is written last and wins.
            if (busy_q[i] && !rdy_q[i]) begin
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (bus.cdb_valid[c] && bus.cdb_tag[cdb_lsb(c, TAG_W) +: TAG_W] == btag_q[i]) begin
                        base_d[i] = bus.cdb_data[cdb_lsb(c, XLEN) +: XLEN];
                        rdy_d[i]  = 1'b1;
                    end
                end
            end
        end

        if (disp_fire) begin
            busy_d[free_idx] = 1'b1;
            dest_d[free_idx] = bus.disp_dest_tag;
            btag_d[free_idx] = bus.disp_base_tag;
            base_d[free_idx] = bus.disp_base;
            rdy_d[free_idx]  = bus.disp_base_rdy;
            off_d[free_idx]  = bus.disp_offset;
            age_d[free_idx]  = AGE_W'(occ_rem);
            if (!bus.disp_base_rdy) begin
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (bus.cdb_valid[c] && bus.cdb_tag[cdb_lsb(c, TAG_W) +: TAG_W] == bus.disp_base_tag) begin
                        base_d[free_idx] = bus.cdb_data[cdb_lsb(c, XLEN) +: XLEN];
                        rdy_d[free_idx]  = 1'b1;
                    end
                end
            end
        end
        occ_d = occ_rem + CNT_W'(disp_fire);

        if (flush) begin
            busy_d = '0;
            iv_d   = 1'b0;
            occ_d  = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            rdy_q  <= '0;
            occ_q  <= '0;
            iv_q   <= 1'b0;
            addr_q <= '0;
            itag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                btag_q[i] <= '0;
                base_q[i] <= '0;
                off_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
            occ_q  <= occ_d;
            iv_q   <= iv_d;
            addr_q <= addr_d;
            itag_q <= itag_d;
            dest_q <= dest_d;
            btag_q <= btag_d;
            base_q <= base_d;
            off_q  <= off_d;
            age_q  <= age_d;
        end
    end
endmodule

// File: doc/load_rs_array.md
# load_rs_array

Parametrised load reservation station for the Tomasulo core. It sits between dispatch and the load unit. It holds up to DEPTH pending loads and snoops NUM_CDB common data buses for a missing base operand. When an entry's base is known it computes base+offset and issues the oldest ready entry to the load unit through a valid/ready handshake. Compared with the fixed 4-entry, 2-CDB station it adds configurable depth and CDB count, oldest-first selection, a registered issue handshake with backpressure, same-cycle CDB bypass at dispatch, an occupancy count, and pipeline flush.

## Interface
- DEPTH, 4: number of entries; must be ≥2.
- XLEN, 32: data and address width.
- TAG_W, 6: ROB tag width.
- NUM_CDB, 2: number of CDB channels snooped.
- CNT_W, $clog2(DEPTH+1): occupancy width (derived).

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high.
- flush, in, 1: synchronous; discard all entries and the issue register.
- disp_valid, in, 1: dispatch presents a load.
- disp_ready, out, 1: station can accept (occupancy < DEPTH).
- disp_dest_tag, in, TAG_W: ROB tag of the load.
- disp_base, in, XLEN: base value, meaningful when disp_base_rdy=1.
- disp_base_rdy, in, 1: base operand already available.
- disp_base_tag, in, TAG_W: producer tag when disp_base_rdy=0.
- disp_offset, in, XLEN: sign-extended immediate.
- cdb_valid, in, NUM_CDB: per-channel broadcast strobe.
- cdb_tag, in, NUM_CDB*TAG_W: packed tags, channel 0 in the LSBs.
- cdb_data, in, NUM_CDB*XLEN: packed data.
- issue_valid, out, 1: issue register holds a load.
- issue_ready, in, 1: load unit accepts.
- issue_addr, out, XLEN: effective address.
- issue_tag, out, TAG_W: ROB tag.
- occupancy, out, CNT_W: valid entries, excluding the issue register.

## Operation
- Entry fields: busy, dest_tag, base, base_rdy, base_tag, offset, age.
- **Dispatch** (disp_valid && disp_ready && !flush):
  - Write the lowest-index free entry.
  - If disp_base_rdy=0 and any cdb channel is valid with a tag equal to disp_base_tag, capture that data with base_rdy=1. The lowest channel wins.
- **Snoop:** every clock, each busy entry with base_rdy=0 compares base_tag against all valid channels. On a match it captures the data (lowest channel wins) and sets base_rdy=1.
- **Age:**
  - A new entry's age is the occupancy value after any same-cycle removal.
  - When an entry leaves, every entry with a larger age decrements.
  - Ages stay a dense 0..occupancy-1; the oldest entry has age 0.
- **Select:**
  - Candidates are entries with busy && base_rdy. The candidate with the smallest age is chosen.
  - Ready status comes from registered state, so a same-cycle CDB capture is not selectable until the next edge.
- **Issue register:**
  - Loads when it is empty or draining (issue_valid && issue_ready) and a candidate exists.
  - On load: issue_addr = base+offset mod 2^XLEN (carry dropped), issue_tag = dest_tag, and the entry's busy clears in the same edge.
  - If it drains and no candidate exists, issue_valid drops.
- **Flush:** all busy bits, ages and issue_valid clear at the edge. Dispatch and snoop in that cycle are ignored.
- **Reset:** asynchronous clear.
  - issue_valid=0, issue_addr=0, issue_tag=0, occupancy=0, disp_ready=1.
  - All entries are non-busy.

## Timing
- disp_ready depends only on registered occupancy. There is no same-cycle credit from a departing entry.
- A dispatch with base ready at edge E0 gives issue_valid=1 after E1 at the earliest.
- A base delivered on the CDB and captured at edge E0 gives issue_valid after E1.
- Dispatch, snoop, selection and issue draining may all occur in one cycle. occupancy changes by +1, 0 or −1.
- issue_valid, issue_addr and issue_tag stay stable while issue_valid && !issue_ready.
- Full station with no ready entries: disp_ready=0 and occupancy=DEPTH. There is no deadlock, because the CDB still updates entries.
- A reset asserted mid-operation clears state immediately. Outputs are valid in the same cycle.

## Structure
- Shared package rs_pkg holds:
  - the tag type;
  - the load entry struct;
  - the load opcode constant;
  - the helper function for unpacking CDB channels.
  
  The other reservation stations reuse it.
- One sub-module, oldest_ready_pick (DEPTH-wide): takes the candidate vector and the ages, and returns a one-hot grant plus a grant-valid flag. It is combinational.
- Everything else (entries, age update, issue register) lives in load_rs_array.

## Test plan
- Reset, then dispatch tag 5 with base 0x1000 ready and offset 0x10 -> after two edges issue_valid=1, issue_addr=0x1010, issue_tag=5. With issue_ready=1, occupancy returns to 0.
- Dispatch tags 1,2,3 waiting on producer 9, then broadcast tag 9 data 0x200 on cdb channel 1 -> all three become ready. They issue in order 1,2,3, one per cycle.
- Hold issue_ready=0 and fill DEPTH entries -> disp_ready=0, occupancy=DEPTH, and issue outputs stay stable. Release -> one entry drains per cycle.
- Dispatch base_tag 7 in the same cycle as cdb channel 0 broadcasting tag 7 data 0xFFFF_FFF0, offset 0x20 -> entry is captured ready and issues with addr 0x0000_0010 (wrap).
- Fill 3 entries with issue_valid=1, then assert flush together with disp_valid -> after the edge issue_valid=0, occupancy=0, and the new load is not stored.
- Assert reset asynchronously mid-burst -> outputs clear before the next edge, and no stale entry issues after release.
